// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, memory depth,
// requester ids and the address range check.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int MEM_DEPTH_DEF = 64;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    localparam int NUM_REQ = 2;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is granted. Purely combinational.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        grant = (req0 & req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer between the CPU data path, the load/debug port and the
// single-port data memory: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RDATA_W   = 16,
    parameter int WDATA_W   = 8,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [WDATA_W-1:0] wdata0,
    output logic               ack0,
    output logic               err0,
    output logic [RDATA_W-1:0] rdata0,
    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata1,
    output logic               ack1,
    output logic               err1,
    output logic [RDATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_write,
    output logic [WDATA_W-1:0] mem_data_in,
    input  logic [RDATA_W-1:0] mem_data_out
);

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              we;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  addr;
    logic [NUM_REQ-1:0][WDATA_W-1:0] wdata;

    assign req   = {req1, req0};
    assign we    = {we1, we0};
    assign addr  = {addr1, addr0};
    assign wdata = {wdata1, wdata0};

    logic [1:0]         state;
    logic               last_grant;
    logic               lat_id;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [WDATA_W-1:0] lat_wdata;

    logic [NUM_REQ-1:0]              ack_q;
    logic [NUM_REQ-1:0]              err_q;
    logic [NUM_REQ-1:0][RDATA_W-1:0] rdata_q;

    logic arb_grant;
    logic arb_valid;
    logic in_range;

    rr_arb2 u_arb (
        .req0       (req[0]),
        .req1       (req[1]),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign in_range = addr_in_range(32'(lat_addr), MEM_DEPTH);

    // Address and data come straight from the latch registers, so they are
    // glitch-free and hold their last value outside ACCESS.
    assign mem_address = lat_addr;
    assign mem_data_in = lat_wdata;
    assign mem_write   = (state == ST_ACCESS) & lat_we & in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= REQ_LOAD;
            lat_id     <= REQ_CPU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        lat_id    <= arb_grant;
                        lat_we    <= we[arb_grant];
                        lat_addr  <= addr[arb_grant];
                        lat_wdata <= wdata[arb_grant];
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Read returns the pre-write word; the write lands on this same edge.
                    rdata_q[lat_id] <= in_range ? mem_data_out : '0;
                    err_q[lat_id]   <= ~in_range;
                    ack_q[lat_id]   <= 1'b1;
                    last_grant      <= lat_id;
                    state           <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q <= '0;
                    err_q <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ack0   = ack_q[0];
    assign ack1   = ack_q[1];
    assign err0   = err_q[0];
    assign err1   = err_q[1];
    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x16 memory model (byte-wide writes).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1, wdata0, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  mem_address;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [15:0] mem_data_out;

    logic [15:0] mem [64];
    logic        mem_init;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .err0         (err0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .err1         (err1),
        .rdata1       (rdata1),
        .mem_address  (mem_address),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    function automatic logic [15:0] init_word(input int i);
        case (i)
            3:       return 16'h3E3E;
            5:       return 16'hA5C3;
            10:      return 16'h1200;
            default: return {8'(i), 8'hEE};
        endcase
    endfunction

    // Out-of-range reads return junk so the DUT's zeroing is observable.
    assign mem_data_out = (mem_address < 8'd64) ? mem[mem_address[5:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_write && mem_address < 8'd64) begin
            mem[mem_address[5:0]][7:0] <= mem_data_in;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int acks;
        logic [7:0] oor [2];
        oor[0] = 8'd64;
        oor[1] = 8'd255;

        reset = 1'b1; mem_init = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) step();
        mem_init = 1'b0;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        reset = 1'b0;

        // Plain read by requester 0
        req0 = 1; we0 = 0; addr0 = 8'd5;
        step();
        chk("rd_access_noack", ack0, 0);
        chk("rd_access_addr", mem_address, 5);
        chk("rd_access_nowrite", mem_write, 0);
        step();
        chk("rd_ack0", ack0, 1);
        chk("rd_rdata0", rdata0, 16'hA5C3);
        chk("rd_err0", err0, 0);
        chk("rd_ack1", ack1, 0);
        req0 = 0;
        step();
        chk("rd_ack0_clear", ack0, 0);
        chk("rd_rdata0_hold", rdata0, 16'hA5C3);

        // Write then read on requester 1
        req1 = 1; we1 = 1; addr1 = 8'd10; wdata1 = 8'h3C;
        step();
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_address", mem_address, 10);
        chk("wr_mem_data_in", mem_data_in, 8'h3C);
        step();
        chk("wr_ack1", ack1, 1);
        chk("wr_rdata1_old", rdata1, 16'h1200);
        chk("wr_mem_write_off", mem_write, 0);
        chk("wr_ack0", ack0, 0);
        req1 = 0; we1 = 0;
        step();
        chk("wr_ack1_clear", ack1, 0);
        req1 = 1; addr1 = 8'd10;
        step();
        step();
        chk("rbw_ack1", ack1, 1);
        chk("rbw_rdata1", rdata1, 16'h123C);
        req1 = 0;
        step();

        // Contention: both held, grants alternate starting with 0
        req0 = 1; we0 = 0; addr0 = 8'd5;
        req1 = 1; we1 = 0; addr1 = 8'd10;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("cont_ack0", ack0, (c % 3 == 2) && ((c / 3) % 2 == 0));
            chk("cont_ack1", ack1, (c % 3 == 2) && ((c / 3) % 2 == 1));
        end
        req0 = 0; req1 = 0;
        step();
        chk("cont_rdata0", rdata0, 16'hA5C3);
        chk("cont_rdata1", rdata1, 16'h123C);

        // Out-of-range writes
        for (int k = 0; k < 2; k++) begin
            req0 = 1; we0 = 1; addr0 = oor[k]; wdata0 = 8'hFF;
            step();
            chk("oor_no_write_a", mem_write, 0);
            step();
            chk("oor_ack0", ack0, 1);
            chk("oor_err0", err0, 1);
            chk("oor_rdata0", rdata0, 0);
            chk("oor_no_write_b", mem_write, 0);
            req0 = 0; we0 = 0;
            step();
            chk("oor_ack0_clear", ack0, 0);
            chk("oor_err0_clear", err0, 0);
        end

        // Reset during ACCESS of a write
        req0 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 8'h77;
        step();
        chk("rstacc_write_on", mem_write, 1);
        #1 reset = 1'b1;
        #1;
        chk("rstacc_write_drop", mem_write, 0);
        chk("rstacc_rdata0", rdata0, 0);
        req0 = 0; we0 = 0;
        step();
        chk("rstacc_ack0", ack0, 0);
        chk("rstacc_word3", mem[3], 16'h3E3E);
        reset = 1'b0;
        req0 = 1; addr0 = 8'd5;
        req1 = 1; addr1 = 8'd10;
        step();
        step();
        chk("post_rst_ack0", ack0, 1);
        chk("post_rst_ack1", ack1, 0);
        chk("post_rst_rdata0", rdata0, 16'hA5C3);
        req0 = 0;
        step();
        step();
        step();
        chk("post_rst_ack1_b", ack1, 1);
        chk("post_rst_rdata1", rdata1, 16'h123C);
        req1 = 0;
        step();

        // Stale request: req0 held past ack gives exactly one extra transaction
        acks = 0;
        req0 = 1; we0 = 0; addr0 = 8'd5;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (ack0) acks++;
            chk("stale_ack0", ack0, (s == 2) || (s == 5));
            chk("stale_ack1", ack1, 0);
            if (s == 4) req0 = 0;
        end
        chk("stale_ack_count", acks, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
